// File: rtl/game24_core.sv
// "Make 24" arithmetic core: conditions switches/keys, sequences a seven-step
// postfix expression over four fixed cards, and drives the result digits and LEDs.
module game24_core #(
  parameter int C1       = 2,
  parameter int C2       = 5,
  parameter int C3       = 4,
  parameter int C4       = 3,
  parameter int DEBOUNCE = 1000000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       st1_i,
  input  logic       st2_i,
  input  logic       st3_i,
  input  logic       st4_i,
  input  logic       st5_i,
  input  logic       st6_i,
  input  logic       st7_i,
  input  logic       plus_i,
  input  logic       minus_i,
  input  logic       multiply_i,
  input  logic       divide_i,
  input  logic       k1_i,
  input  logic       k2_i,
  input  logic       k3_i,
  input  logic       k4_i,
  output logic [6:0] y_o,
  output logic [6:0] y_1_o,
  output logic [6:0] y_2_o,
  output logic [6:0] y_3_o,
  output logic [6:0] y_4_o,
  output logic [6:0] y_5_o,
  output logic       L0_o,
  output logic       L1_o,
  output logic       L2_o,
  output logic       L3_o,
  output logic       L4_o,
  output logic       L5_o,
  output logic       L6_o,
  output logic       L7_o,
  output logic       L8_o,
  output logic       L9_o
);

  localparam int NIN = 15;
  localparam int CW  = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_LOAD = CW'(DEBOUNCE - 1);
  localparam logic [3:0] CV1 = 4'(C1);
  localparam logic [3:0] CV2 = 4'(C2);
  localparam logic [3:0] CV3 = 4'(C3);
  localparam logic [3:0] CV4 = 4'(C4);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;

  typedef enum logic [1:0] {S_RUN, S_OP, S_ERR} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Input bit order: st1..st7, plus, minus, multiply, divide, k1..k4.
  logic [NIN-1:0] raw, sync1_q, sync2_q, deb_q, deb_d;
  logic [CW-1:0]  cnt_q [NIN];
  logic [CW-1:0]  cnt_d [NIN];
  logic [6:0]     st_prev_q;

  assign raw = {k4_i, k3_i, k2_i, k1_i, divide_i, multiply_i, minus_i, plus_i,
                st7_i, st6_i, st5_i, st4_i, st3_i, st2_i, st1_i};

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = DB_LOAD;
      end else if (cnt_q[i] == '0) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = DB_LOAD;
      end else begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      st_prev_q <= '0;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= DB_LOAD;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      st_prev_q <= deb_q[6:0];
      for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic [6:0] st_deb, rise, exp_edge;
  logic [3:0] op_deb, key_deb, key_val;
  assign st_deb  = deb_q[6:0];
  assign op_deb  = deb_q[10:7];
  assign key_deb = deb_q[14:11];
  assign rise    = st_deb & ~st_prev_q;
  assign key_val = ({4{key_deb[0]}} & CV1) | ({4{key_deb[1]}} & CV2) |
                   ({4{key_deb[2]}} & CV3) | ({4{key_deb[3]}} & CV4);

  state_t             state_q, state_d;
  logic [3:0]         step_q, step_d;
  logic signed [15:0] acc_q, acc_d;
  logic [3:0]         used_q, used_d, card_a_q, card_a_d, card_b_q, card_b_d, op_q, op_d;
  logic [6:0]         done_q, done_d;
  logic               disp_q, disp_d, win_q, win_d, lose_q, lose_d;

  // Step 8 shifts the single bit out, so any edge after step 7 is an error.
  assign exp_edge = 7'd1 << (step_q - 4'd1);

  logic signed [15:0] left, right, right_nz, result, quot, rem;
  logic               div_bad, card_step, restart;

  always_comb begin
    left     = (step_q == 4'd4) ? $signed({12'd0, card_a_q}) : acc_q;
    right    = $signed({12'd0, card_b_q});
    right_nz = (right == 16'sd0) ? 16'sd1 : right;
    quot     = left / right_nz;
    rem      = left % right_nz;
    result   = quot;
    if (op_q[0])      result = left + right;
    else if (op_q[1]) result = left - right;
    else if (op_q[2]) result = left * right;
    div_bad  = op_q[3] && ((right == 16'sd0) || (rem != 16'sd0));
  end

  assign card_step = (step_q == 4'd1) || (step_q == 4'd2) || (step_q == 4'd4) || (step_q == 4'd6);
  assign restart   = (st_deb == '0) && ((step_q > 4'd1) || (state_q == S_ERR));

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    acc_d    = acc_q;
    used_d   = used_q;
    card_a_d = card_a_q;
    card_b_d = card_b_q;
    op_d     = op_q;
    done_d   = done_q;
    disp_d   = disp_q;
    win_d    = win_q;
    lose_d   = lose_q;
    case (state_q)
      S_RUN: begin
        if (rise != '0) begin
          if (rise != exp_edge) begin
            state_d = S_ERR;
          end else if (card_step) begin
            if (!$onehot(key_deb) || ((used_q & key_deb) != '0)) begin
              state_d = S_ERR;
            end else begin
              used_d = used_q | key_deb;
              if (step_q == 4'd1) card_a_d = key_val;
              else                card_b_d = key_val;
              done_d = done_q | exp_edge;
              step_d = step_q + 4'd1;
            end
          end else if (!$onehot(op_deb)) begin
            state_d = S_ERR;
          end else begin
            op_d    = op_deb;
            done_d  = done_q | exp_edge;
            step_d  = step_q + 4'd1;
            state_d = S_OP;
          end
        end
      end
      S_OP: begin
        if (div_bad) begin
          state_d = S_ERR;
        end else begin
          acc_d   = result;
          disp_d  = 1'b1;
          state_d = S_RUN;
          if (step_q == 4'd8) begin
            win_d  = (result == 16'sd24);
            lose_d = (result != 16'sd24);
          end
        end
      end
      default: ;
    endcase
    if (restart) begin
      state_d = S_RUN;
      step_d  = 4'd1;
      acc_d   = '0;
      used_d  = '0;
      done_d  = '0;
      disp_d  = 1'b0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q  <= S_RUN;
      step_q   <= 4'd1;
      acc_q    <= '0;
      used_q   <= '0;
      card_a_q <= '0;
      card_b_q <= '0;
      op_q     <= '0;
      done_q   <= '0;
      disp_q   <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      used_q   <= used_d;
      card_a_q <= card_a_d;
      card_b_q <= card_b_d;
      op_q     <= op_d;
      done_q   <= done_d;
      disp_q   <= disp_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
    end
  end

  always_comb begin
    y_4_o = SEG_BLANK;
    y_5_o = SEG_BLANK;
    if (state_q == S_ERR) begin
      y_4_o = SEG_E;
      y_5_o = SEG_E;
    end else if (disp_q) begin
      if (acc_q >= 16'sd0 && acc_q <= 16'sd99) begin
        y_4_o = seg7(4'(acc_q[6:0] / 7'd10));
        y_5_o = seg7(4'(acc_q[6:0] % 7'd10));
      end else if (acc_q < 16'sd0 && acc_q >= -16'sd9) begin
        y_4_o = SEG_MINUS;
        y_5_o = seg7(4'(-acc_q));
      end else begin
        y_4_o = SEG_MINUS;
        y_5_o = SEG_MINUS;
      end
    end
  end

  assign y_o   = seg7(CV1);
  assign y_1_o = seg7(CV2);
  assign y_2_o = seg7(CV3);
  assign y_3_o = seg7(CV4);
  assign {L6_o, L5_o, L4_o, L3_o, L2_o, L1_o, L0_o} = done_q;
  assign L7_o  = (state_q == S_ERR);
  assign L8_o  = win_q;
  assign L9_o  = lose_q;

endmodule

// File: tb/tb_game24_core.sv
// Scoreboard bench for game24_core: directed game scenarios plus random rounds,
// each step's expected display/LED state produced by a high-level round model.
module tb_game24_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] st = '0;
  logic [3:0] opk = '0;
  logic [3:0] keys = '0;
  logic [6:0] y0, y1, y2, y3, y4, y5;
  logic L0, L1, L2, L3, L4, L5, L6, L7, L8, L9;

  always #5 clk = ~clk;

  game24_core #(.C1(2), .C2(5), .C3(4), .C4(3), .DEBOUNCE(4)) dut (
    .clock_i(clk), .reset_i(rst_n),
    .st1_i(st[0]), .st2_i(st[1]), .st3_i(st[2]), .st4_i(st[3]),
    .st5_i(st[4]), .st6_i(st[5]), .st7_i(st[6]),
    .plus_i(opk[0]), .minus_i(opk[1]), .multiply_i(opk[2]), .divide_i(opk[3]),
    .k1_i(keys[0]), .k2_i(keys[1]), .k3_i(keys[2]), .k4_i(keys[3]),
    .y_o(y0), .y_1_o(y1), .y_2_o(y2), .y_3_o(y3), .y_4_o(y4), .y_5_o(y5),
    .L0_o(L0), .L1_o(L1), .L2_o(L2), .L3_o(L3), .L4_o(L4),
    .L5_o(L5), .L6_o(L6), .L7_o(L7), .L8_o(L8), .L9_o(L9)
  );

  typedef struct packed {
    logic [9:0] leds;
    logic [6:0] d4;
    logic [6:0] d5;
  } exp_t;

  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'h3F;
  localparam logic [6:0] ECHR  = 7'h06;
  int cv [4] = '{2, 5, 4, 3};

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Round model
  int m_step, m_acc, m_a, m_b;
  bit m_used [4];
  bit m_err, m_disp, m_win, m_lose;
  bit [6:0] m_done;

  task automatic model_reset();
    m_step = 1; m_acc = 0; m_a = 0; m_b = 0;
    for (int i = 0; i < 4; i++) m_used[i] = 1'b0;
    m_err = 1'b0; m_disp = 1'b0; m_win = 1'b0; m_lose = 1'b0; m_done = '0;
  endtask

  task automatic model_step(input int n, input logic [3:0] kk, input logic [3:0] oo);
    int idx, left, res;
    if (m_err) return;
    if (n != m_step) begin m_err = 1'b1; return; end
    if (n == 1 || n == 2 || n == 4 || n == 6) begin
      if ($countones(kk) != 1) begin m_err = 1'b1; return; end
      idx = 0;
      for (int i = 0; i < 4; i++) if (kk[i]) idx = i;
      if (m_used[idx]) begin m_err = 1'b1; return; end
      m_used[idx] = 1'b1;
      if (n == 1) m_a = cv[idx]; else m_b = cv[idx];
      m_done[n-1] = 1'b1;
      m_step++;
    end else begin
      if ($countones(oo) != 1) begin m_err = 1'b1; return; end
      m_done[n-1] = 1'b1;
      m_step++;
      left = (n == 3) ? m_a : m_acc;
      if (oo[0])      res = left + m_b;
      else if (oo[1]) res = left - m_b;
      else if (oo[2]) res = left * m_b;
      else begin
        if (m_b == 0 || (left % m_b) != 0) begin m_err = 1'b1; return; end
        res = left / m_b;
      end
      m_acc = res;
      m_disp = 1'b1;
      if (n == 7) begin m_win = (res == 24); m_lose = (res != 24); end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.leds = {m_lose, m_win, m_err, m_done};
    if (m_err) begin e.d4 = ECHR; e.d5 = ECHR; end
    else if (!m_disp) begin e.d4 = BLANK; e.d5 = BLANK; end
    else if (m_acc >= 0 && m_acc <= 99) begin e.d4 = segtab[m_acc / 10]; e.d5 = segtab[m_acc % 10]; end
    else if (m_acc >= -9 && m_acc < 0) begin e.d4 = MINUS; e.d5 = segtab[-m_acc]; end
    else begin e.d4 = MINUS; e.d5 = MINUS; end
    return e;
  endfunction

  task automatic expect_model();
    sb.push_back(model_out());
  endtask

  task automatic expect_const(input logic [9:0] leds, input logic [6:0] d4, input logic [6:0] d5);
    exp_t e;
    e.leds = leds; e.d4 = d4; e.d5 = d5;
    sb.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int n, input logic [3:0] kk, input logic [3:0] oo);
    keys = kk; opk = oo;
    cyc(12);
    st[n-1] = 1'b1;
    cyc(12);
    model_step(n, kk, oo);
    expect_model();
  endtask

  task automatic restart();
    st = '0; keys = '0; opk = '0;
    cyc(15);
    model_reset();
    expect_model();
  endtask

  task automatic win_path();
    press(1, 4'b1000, 4'b0000);
    press(2, 4'b0100, 4'b0000);
    press(3, 4'b0000, 4'b0001);
    expect_const(10'b0000000111, segtab[0], segtab[7]);
    press(4, 4'b0010, 4'b0000);
    press(5, 4'b0000, 4'b0001);
    expect_const(10'b0000011111, segtab[1], segtab[2]);
    press(6, 4'b0001, 4'b0000);
    press(7, 4'b0000, 4'b0100);
    expect_const(10'b0101111111, segtab[2], segtab[4]);
  endtask

  function automatic int pick_unused();
    int c[$];
    for (int i = 0; i < 4; i++) if (!m_used[i]) c.push_back(i);
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  function automatic int pick_used();
    int c[$];
    for (int i = 0; i < 4; i++) if (m_used[i]) c.push_back(i);
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  task automatic random_round();
    int n, kind, idx, j;
    logic [3:0] kk, oo;
    for (int s = 1; s <= 7 && !m_err; s++) begin
      kk = '0; oo = '0; n = s;
      kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (s == 1 || s == 2 || s == 4 || s == 6) begin
        if (kind == 3 && s == 1) kind = 2;
        idx = $urandom_range(0, 3);
        j = (idx + int'($urandom_range(1, 3))) % 4;
        case (kind)
          0: kk[pick_unused()] = 1'b1;
          1: kk = '0;
          2: begin kk[idx] = 1'b1; kk[j] = 1'b1; end
          default: kk[pick_used()] = 1'b1;
        endcase
      end else begin
        if (kind == 3 && s == 7) kind = 1;
        idx = $urandom_range(0, 3);
        j = (idx + int'($urandom_range(1, 3))) % 4;
        oo[idx] = 1'b1;
        if (kind == 1) oo = '0;
        else if (kind == 2) oo[j] = 1'b1;
        else if (kind == 3) n = $urandom_range(s + 1, 7);
      end
      press(n, kk, oo);
    end
    restart();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  exp_t cur;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk("leds", {22'd0, L9, L8, L7, L6, L5, L4, L3, L2, L1, L0}, {22'd0, cur.leds});
      chk("y_4", {25'd0, y4}, {25'd0, cur.d4});
      chk("y_5", {25'd0, y5}, {25'd0, cur.d5});
      chk("cards", {4'd0, y0, y1, y2, y3}, {4'd0, segtab[cv[0]], segtab[cv[1]], segtab[cv[2]], segtab[cv[3]]});
    end
  end

  initial begin
    #5000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    cyc(5);
    rst_n = 1'b1;
    cyc(2);
    model_reset();
    expect_model();
    expect_const(10'b0, BLANK, BLANK);

    win_path();
    restart();
    expect_const(10'b0, BLANK, BLANK);
    win_path();
    restart();

    press(1, 4'b0001, 4'b0000);
    press(2, 4'b0010, 4'b0000);
    press(3, 4'b0000, 4'b0010);
    expect_const(10'b0000000111, MINUS, segtab[3]);
    press(4, 4'b0100, 4'b0000);
    press(5, 4'b0000, 4'b0001);
    press(6, 4'b1000, 4'b0000);
    press(7, 4'b0000, 4'b0100);
    expect_const(10'b1001111111, segtab[0], segtab[3]);
    restart();

    press(1, 4'b0001, 4'b0000);
    press(2, 4'b0001, 4'b0000);
    expect_const(10'b0010000001, ECHR, ECHR);
    restart();
    expect_const(10'b0, BLANK, BLANK);

    press(1, 4'b0001, 4'b0000);
    press(3, 4'b0000, 4'b0001);
    expect_const(10'b0010000001, ECHR, ECHR);
    restart();

    press(1, 4'b0010, 4'b0000);
    press(2, 4'b0001, 4'b0000);
    press(3, 4'b0000, 4'b1000);
    expect_const(10'b0010000111, ECHR, ECHR);
    restart();
    expect_const(10'b0, BLANK, BLANK);

    press(1, 4'b1000, 4'b0000);
    press(2, 4'b0100, 4'b0000);
    press(3, 4'b0000, 4'b0001);
    press(4, 4'b0010, 4'b0000);
    rst_n = 1'b0;
    cyc(1);
    model_reset();
    expect_model();
    st = '0; keys = '0; opk = '0;
    cyc(5);
    rst_n = 1'b1;
    cyc(3);
    expect_model();
    win_path();
    restart();

    for (int r = 0; r < 40; r++) random_round();

    cyc(3);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
